// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions.
// Holds the canonical NOP, fetch fault codes and the instruction-memory states.
package riscv_pkg;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_e;

    typedef enum logic {
        IMEM_BOOT = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous word RAM with a registered read port.
// Contents are never reset; only the read register is.
module imem_ram #(
    parameter int DEPTH = 256,
    parameter int XLEN  = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            re,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register holds its value when re is low, which keeps a stalled response stable.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction memory with boot-time loader and valid/ready fetch port.
// One-cycle fetch latency, back-pressure, flush and PC fault reporting.
module imem_fetch_port
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_done,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_instr,
    output logic [1:0]      resp_fault,
    output logic [XLEN-1:0] resp_pc,
    output logic            boot
);

    imem_state_e     state_q, state_d;
    logic            resp_valid_q, resp_valid_d;
    fault_e          fault_q, fault_d;
    logic [XLEN-1:0] pc_q, pc_d;

    fault_e          req_fault;
    logic            accept;
    logic            ram_we;
    logic            ram_re;
    logic [AW-1:0]   ram_addr;
    logic [XLEN-1:0] ram_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IMEM_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IMEM_BOOT: if (load_done) state_d = IMEM_RUN;
            IMEM_RUN:  state_d = IMEM_RUN;
            default:   state_d = IMEM_BOOT;
        endcase
    end

    assign boot = (state_q == IMEM_BOOT);

    // Misalignment outranks range: a misaligned PC never reaches the range check.
    always_comb begin
        req_fault = FAULT_NONE;
        if (req_pc[1:0] != 2'b00) begin
            req_fault = FAULT_MISALIGN;
        end else if (|req_pc[XLEN-1:AW+2]) begin
            req_fault = FAULT_RANGE;
        end
    end

    assign req_ready = (state_q == IMEM_RUN) && !flush
                       && (!resp_valid_q || resp_ready);
    assign accept    = req_valid && req_ready;

    assign ram_we   = boot && load_en;
    assign ram_re   = accept && (req_fault == FAULT_NONE);
    assign ram_addr = boot ? load_addr : req_pc[AW+1:2];

    imem_ram #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (load_data),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

    always_comb begin
        resp_valid_d = resp_valid_q;
        fault_d      = fault_q;
        pc_d         = pc_q;
        if (flush) begin
            resp_valid_d = 1'b0;
        end else if (accept) begin
            resp_valid_d = 1'b1;
            fault_d      = req_fault;
            pc_d         = req_pc;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            fault_q      <= FAULT_NONE;
            pc_q         <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
            pc_q         <= pc_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_fault = fault_q;
    assign resp_pc    = pc_q;
    assign resp_instr = (fault_q != FAULT_NONE) ? XLEN'(INSTR_NOP) : ram_rdata;

endmodule

// File: doc/imem_fetch_port.md
# imem_fetch_port

Parametrised, synchronous instruction memory for the RISC-V datapath with a boot-time load port and a valid/ready fetch interface. During BOOT the memory is filled word-by-word by the loader. In RUN it serves one fetch per cycle to the IF stage with one-cycle latency, back-pressure, flush, and fault reporting for misaligned or out-of-range PCs. It sits between the PC register and the IF/ID pipeline register.

## Interface
Parameters:
- XLEN, 32, instruction and address width
- DEPTH, 256, memory depth in words; power of two, ≥ 4
- AW, $clog2(DEPTH), derived word-index width; not overridden

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- load_en  in  1  write one word (BOOT only)
- load_addr  in  AW  word index for load
- load_data  in  XLEN  word to write
- load_done  in  1  pulse: leave BOOT, enter RUN
- req_valid  in  1  fetch request present
- req_ready  out  1  fetch request accepted this cycle
- req_pc  in  XLEN  byte address of instruction
- flush  in  1  discard pending response (branch/jump taken)
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_instr  out  XLEN  fetched instruction, or NOP on fault
- resp_fault  out  2  fault code: 00 none, 01 misaligned, 10 out-of-range
- resp_pc  out  XLEN  PC of the returned instruction
- boot  out  1  high while in BOOT

## Operation
- States: BOOT, RUN. Reset enters BOOT. BOOT→RUN on load_done; RUN is left only by reset.
- BOOT:
  - load_en writes load_data to mem[load_addr] at the clock edge.
  - req_ready=0.
  - load_en together with load_done: the write completes and the state becomes RUN on the same edge.
- RUN:
  - load_en is ignored and the memory is read-only.
  - req_ready = !flush && (!resp_valid || resp_ready).
  - On accept (req_valid && req_ready), evaluate the fault:
    - misaligned if req_pc[1:0] != 0
    - otherwise out-of-range if req_pc[XLEN-1:2] ≥ DEPTH
    - misaligned has priority over out-of-range.
  - Fault responses return resp_instr = 32'h0000_0013 (NOP); the array read is suppressed.
- Back-pressure: while resp_valid && !resp_ready, resp_instr/resp_fault/resp_pc are held stable. No new request is accepted.
- Flush:
  - resp_valid clears at the next edge.
  - No request is accepted in the flush cycle.
  - Flush has priority over resp_ready and req_valid.
- Memory contents are not cleared by reset and are undefined until loaded.
- Word index = req_pc[AW+1:2].

## Timing
- Reset values: resp_valid=0, resp_instr=0, resp_fault=00, resp_pc=0, boot=1, req_ready=0.
- Latency: a request accepted at edge N gives resp_valid=1 with its data after edge N. Outputs are registered.
- Throughput is 1 fetch/cycle when resp_ready is held high. The read and the output-register update happen at the same edge, so there are no bubbles.
- If resp_ready=1 and a new request is accepted in the same cycle, the output register is replaced at that edge.
- A load to address A followed by load_done lets a fetch of A×4 accepted in the first RUN cycle return the loaded data.
- Reset mid-operation: a pending response is dropped and the block returns to BOOT. Memory is retained.
- boot deasserts the cycle after the load_done edge.

## Structure
- Shared package riscv_pkg holds:
  - INSTR_NOP = 32'h0000_0013
  - fault enum {FAULT_NONE, FAULT_MISALIGN, FAULT_RANGE}
  - imem state enum {IMEM_BOOT, IMEM_RUN}
- Sub-module imem_ram: single-port synchronous RAM with parameters DEPTH and XLEN. Ports: we, addr, wdata, re, rdata. rdata is registered.
- The top level owns the FSM, fault decode, handshake and output holding. rdata is muxed with NOP when the registered fault is non-zero.

## Test plan
- Load 0x00A00093 @0, 0x00100113 @1, then load_done; fetch PC 0, 4 back-to-back with resp_ready=1 → responses 0x00A00093 and 0x00100113 on consecutive cycles, fault 00.
- Request in BOOT with req_valid=1 → req_ready=0 and resp_valid stays 0. load_en+load_done in the same cycle → the word is written and boot=0 on the next cycle.
- Fetch PC 0x6 → resp_instr 0x00000013, fault 01. Fetch PC DEPTH×4 → NOP, fault 10. Fetch PC 0x402 with DEPTH=256 → fault 01 (priority).
- resp_ready=0 for 3 cycles after a response to PC 4 → outputs held, req_ready=0. Release → next request accepted that cycle.
- Flush while resp_valid=1 and req_valid=1 → resp_valid=0 next cycle and the request is not accepted. The re-issued request is served one cycle later.
- In RUN, load_en writes 0xFFFFFFFF @0 → fetch PC 0 still returns 0x00A00093. Reset → boot=1, resp_valid=0, memory retained after a new load_done.
